// File: rtl/syscall_print_ctrl.sv
// Console print controller for print_string (v0=4) and print_char (v0=11).
// Define SYSCALL_MAXLEN_EN to cap each print_string at MAX_LEN characters.
module syscall_print_ctrl #(
    parameter int MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] SVC_PRINT_STRING = 32'd4;
    localparam logic [31:0] SVC_PRINT_CHAR   = 32'd11;

    if (MAX_LEN < 1) begin : g_bad_max_len
        $error("MAX_LEN must be at least 1");
    end

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ptr;
    logic [7:0]  chr;
    logic        str_mode;
    logic [7:0]  sel_byte;
    logic        last_char;
    logic        handshake;

`ifdef SYSCALL_MAXLEN_EN
    localparam int CW = ($clog2(MAX_LEN + 1) > 8) ? $clog2(MAX_LEN + 1) : 8;
    logic [CW-1:0] count;
`endif

    // Little-endian byte lane picked by the low pointer bits.
    always_comb begin
        case (ptr[1:0])
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
    end

    assign handshake = (state == EMIT) && char_ready;

`ifdef SYSCALL_MAXLEN_EN
    assign last_char = (count == CW'(MAX_LEN - 1));
`else
    assign last_char = 1'b0;
`endif

    // NOTE: the state register is only the flop; all decisions live in the
    // always_comb below, which assigns every output a default first so no
    // latch can be inferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_read   = 1'b0;
        char_valid = 1'b0;
        char_out   = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;
        mem_addr   = {ptr[31:2], 2'b00};
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (syscall) begin
                    if (v0 == SVC_PRINT_STRING) begin
                        state_nxt = FETCH;
                    end else if (v0 == SVC_PRINT_CHAR) begin
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            FETCH: begin
                mem_read  = 1'b1;
                state_nxt = (sel_byte == 8'h00) ? DONE : EMIT;
            end
            EMIT: begin
                char_valid = 1'b1;
                char_out   = chr;
                if (char_ready) begin
                    state_nxt = (str_mode && !last_char) ? FETCH : DONE;
                end
            end
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= 32'h0;
            chr      <= 8'h00;
            str_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (syscall && v0 == SVC_PRINT_STRING) begin
                        ptr      <= a0;
                        str_mode <= 1'b1;
                    end else if (syscall && v0 == SVC_PRINT_CHAR) begin
                        chr      <= a0[7:0];
                        str_mode <= 1'b0;
                    end
                end
                FETCH: begin
                    if (sel_byte != 8'h00) begin
                        chr <= sel_byte;
                    end
                end
                EMIT: begin
                    // Natural 32-bit overflow gives the required silent wrap.
                    if (handshake && str_mode) begin
                        ptr <= ptr + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYSCALL_MAXLEN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (state == IDLE && syscall && v0 == SVC_PRINT_STRING) begin
            count <= '0;
        end else if (handshake && str_mode) begin
            count <= count + CW'(1);
        end
    end
`endif

endmodule
